// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: grants init/refresh/write/read engines and muxes their pins.
// Optional ARB_ROUND_ROBIN_EN: alternates write/read on collision instead of write-first.
module sdram_arbit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  localparam logic [2:0] ARB_IDLE  = 3'd0;
  localparam logic [2:0] ARB_ARBIT = 3'd1;
  localparam logic [2:0] ARB_AREF  = 3'd2;
  localparam logic [2:0] ARB_WRITE = 3'd3;
  localparam logic [2:0] ARB_READ  = 3'd4;
  localparam logic [3:0] CMD_NOP   = 4'b0111;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_wr_win;
  logic       w_rd_win;
  logic [3:0] w_cmd;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_wr <= 1'b0;
    end else if (r_state == ARB_ARBIT && !aref_req) begin
      if (w_wr_win)
        r_last_wr <= 1'b1;
      else if (w_rd_win)
        r_last_wr <= 1'b0;
    end
  end

  // On a collision the engine not served last time wins.
  assign w_wr_win = wr_req && (!rd_req || !r_last_wr);
`else
  assign w_wr_win = wr_req;
`endif

  assign w_rd_win = rd_req && !w_wr_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ARB_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (init_end) w_next = ARB_ARBIT;
      ARB_ARBIT: begin
        if (aref_req)      w_next = ARB_AREF;
        else if (w_wr_win) w_next = ARB_WRITE;
        else if (w_rd_win) w_next = ARB_READ;
      end
      ARB_AREF:  if (aref_end) w_next = ARB_ARBIT;
      ARB_WRITE: if (wr_end)   w_next = ARB_ARBIT;
      ARB_READ:  if (rd_end)   w_next = ARB_ARBIT;
      default:   w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    w_cmd      = init_cmd;
    sdram_ba   = init_bank;
    sdram_addr = init_addr;
    case (r_state)
      ARB_ARBIT: begin
        aref_en    = aref_req;
        wr_en      = !aref_req && w_wr_win;
        rd_en      = !aref_req && w_rd_win;
        w_cmd      = CMD_NOP;
        sdram_ba   = {BANK_W{1'b1}};
        sdram_addr = {ADDR_W{1'b1}};
      end
      ARB_AREF: begin
        w_cmd      = aref_cmd;
        sdram_ba   = aref_bank;
        sdram_addr = aref_addr;
      end
      ARB_WRITE: begin
        w_cmd      = wr_cmd;
        sdram_ba   = wr_bank;
        sdram_addr = wr_addr;
      end
      ARB_READ: begin
        w_cmd      = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
  assign sdram_cke = 1'b1;

  // DQ follows the write engine's enable regardless of arbiter state.
  assign sdram_dq = wr_sdram_en ? wr_sdram_data : {DATA_W{1'bz}};

endmodule
